// File: rtl/intr_pkg.sv
// Shared constants for the interrupt controller: register offsets, id width and FSM states.
package intr_pkg;
   localparam int ID_W = 5;
   localparam logic [ID_W-1:0] TIMER_ID = '0;

   localparam logic [4:0] OFF_PENDING  = 5'h00;
   localparam logic [4:0] OFF_ENABLE   = 5'h04;
   localparam logic [4:0] OFF_MODE     = 5'h08;
   localparam logic [4:0] OFF_CLAIM    = 5'h0C;
   localparam logic [4:0] OFF_MTIME_LO = 5'h10;
   localparam logic [4:0] OFF_MTIME_HI = 5'h14;
   localparam logic [4:0] OFF_MCMP_LO  = 5'h18;
   localparam logic [4:0] OFF_MCMP_HI  = 5'h1C;

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
endpackage

// File: rtl/intr_sync.sv
// Per-source synchroniser followed by level (mode=0) or rising-edge (mode=1) detection.
module intr_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic src,
   input  logic mode,
   output logic evt
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], src};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign evt = mode ? (sync_q[SYNC_STAGES-1] & ~prev_q) : sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: synchronised sources, pending/enable/mode registers, fixed priority,
// single-level request/service handshake. Optional machine timer under INTR_CTRL_TIMER_EN.
module intr_ctrl
   import intr_pkg::*;
#(
   parameter int NUM_SRC     = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] src_i,
   input  logic [4:0]         reg_addr,
   input  logic               reg_wr,
   input  logic [31:0]        reg_wdata,
   output logic [31:0]        reg_rdata,
   output logic               intr_req,
   output logic [ID_W-1:0]    intr_id,
   input  logic               intr_ack,
   input  logic               intr_done,
   output logic               e_intr,
   output logic               t_intr
);
   logic [NUM_SRC-1:0] evt, pend_q, en_q, mode_q, clr;
   state_t             state_q, state_d;
   logic [ID_W-1:0]    id_q, id_d, win_id;
   logic               win_vld, claim, timer_pend;
   logic               unused_wdata;

   assign unused_wdata = ^reg_wdata;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      intr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk  (clk),
         .rst  (rst),
         .src  (src_i[g]),
         .mode (mode_q[g]),
         .evt  (evt[g])
      );
   end

   // Clear from W1C or claim; the OR with evt afterwards makes a same-cycle set win.
   always_comb begin
      clr = '0;
      for (int k = 0; k < NUM_SRC; k++)
         clr[k] = (reg_wr && reg_addr == OFF_PENDING && reg_wdata[k]) ||
                  (claim && id_q == ID_W'(k + 1));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_q <= '0;
         en_q   <= '0;
         mode_q <= '0;
      end else begin
         pend_q <= (pend_q & ~clr) | evt;
         if (reg_wr && reg_addr == OFF_ENABLE) en_q   <= reg_wdata[NUM_SRC-1:0];
         if (reg_wr && reg_addr == OFF_MODE)   mode_q <= reg_wdata[NUM_SRC-1:0];
      end
   end

`ifdef INTR_CTRL_TIMER_EN
   logic [63:0] mtime_q, mcmp_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mtime_q <= '0;
         mcmp_q  <= '1;
      end else begin
         // A write to either half suppresses the increment for that cycle.
         if (reg_wr && reg_addr == OFF_MTIME_LO)      mtime_q[31:0]  <= reg_wdata;
         else if (reg_wr && reg_addr == OFF_MTIME_HI) mtime_q[63:32] <= reg_wdata;
         else                                          mtime_q        <= mtime_q + 64'd1;
         if (reg_wr && reg_addr == OFF_MCMP_LO) mcmp_q[31:0]  <= reg_wdata;
         if (reg_wr && reg_addr == OFF_MCMP_HI) mcmp_q[63:32] <= reg_wdata;
      end
   end

   assign timer_pend = (mtime_q >= mcmp_q);
`else
   assign timer_pend = 1'b0;
`endif

   always_comb begin
      reg_rdata = '0;
      case (reg_addr)
         OFF_PENDING:  reg_rdata[NUM_SRC-1:0] = pend_q;
         OFF_ENABLE:   reg_rdata[NUM_SRC-1:0] = en_q;
         OFF_MODE:     reg_rdata[NUM_SRC-1:0] = mode_q;
         OFF_CLAIM:    reg_rdata[ID_W-1:0]    = id_q;
`ifdef INTR_CTRL_TIMER_EN
         OFF_MTIME_LO: reg_rdata = mtime_q[31:0];
         OFF_MTIME_HI: reg_rdata = mtime_q[63:32];
         OFF_MCMP_LO:  reg_rdata = mcmp_q[31:0];
         OFF_MCMP_HI:  reg_rdata = mcmp_q[63:32];
`endif
         default:      reg_rdata = '0;
      endcase
   end

   // Lowest enabled pending source wins; a pending timer overrides all sources.
   always_comb begin
      win_vld = 1'b0;
      win_id  = TIMER_ID;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         if (pend_q[k] && en_q[k]) begin
            win_vld = 1'b1;
            win_id  = ID_W'(k + 1);
         end
      end
      if (timer_pend) begin
         win_vld = 1'b1;
         win_id  = TIMER_ID;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
      end
   end

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      claim   = 1'b0;
      case (state_q)
         IDLE: if (win_vld) begin
            state_d = REQ;
            id_d    = win_id;
         end
         REQ: if (intr_ack) begin
            state_d = SERVICE;
            claim   = 1'b1;
         end
         SERVICE: if (intr_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign intr_req = (state_q == REQ);
   assign intr_id  = id_q;
   assign e_intr   = intr_req && (id_q != TIMER_ID);
`ifdef INTR_CTRL_TIMER_EN
   assign t_intr   = intr_req && (id_q == TIMER_ID);
`else
   assign t_intr   = 1'b0;
`endif
endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl; timer checks compile in only with INTR_CTRL_TIMER_EN.
module tb_intr_ctrl;
   import intr_pkg::*;
   localparam int NS = 8;
   localparam int SS = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [NS-1:0] src_i;
   logic [4:0]    reg_addr;
   logic          reg_wr;
   logic [31:0]   reg_wdata, reg_rdata;
   logic          intr_req, intr_ack, intr_done, e_intr, t_intr;
   logic [4:0]    intr_id;
   logic [31:0]   v;
   logic          seen;
   int            checks = 0;
   int            failures = 0;

   intr_ctrl #(.NUM_SRC(NS), .SYNC_STAGES(SS)) dut (
      .clk(clk), .rst(rst), .src_i(src_i), .reg_addr(reg_addr), .reg_wr(reg_wr),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .intr_req(intr_req), .intr_id(intr_id),
      .intr_ack(intr_ack), .intr_done(intr_done), .e_intr(e_intr), .t_intr(t_intr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      reg_addr = a; reg_wdata = d; reg_wr = 1'b1;
      @(negedge clk);
      reg_wr = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      @(negedge clk);
      reg_addr = a;
      #1 d = reg_rdata;
   endtask

   task automatic ack();
      @(negedge clk); intr_ack = 1'b1;
      @(negedge clk); intr_ack = 1'b0;
   endtask

   task automatic done();
      @(negedge clk); intr_done = 1'b1;
      @(negedge clk); intr_done = 1'b0;
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_req(input string tag, input int max);
      for (int i = 0; i < max; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (intr_req) break;
      end
      chk(tag, intr_req, 1'b1);
   endtask

   initial begin
      rst = 1'b0; src_i = '0; reg_addr = '0; reg_wr = 1'b0; reg_wdata = '0;
      intr_ack = 1'b0; intr_done = 1'b0;
      settle(3);
      chk("rst_req", intr_req, 1'b0);
      chk("rst_id", intr_id, 5'd0);
      rd(OFF_PENDING, v); chk("rst_pend", v, 32'h0);
`ifdef INTR_CTRL_TIMER_EN
      rd(OFF_MCMP_LO, v); chk("rst_mcmp_lo", v, 32'hFFFF_FFFF);
`else
      rd(OFF_MCMP_LO, v); chk("rst_mcmp_lo_off", v, 32'h0);
`endif
      @(negedge clk); rst = 1'b1;

      // Level source 3
      wr(OFF_ENABLE, 32'h08);
      rd(OFF_ENABLE, v); chk("en_rb", v, 32'h08);
      @(negedge clk); src_i[3] = 1'b1;
      wait_req("lvl_req", SS + 2);
      chk("lvl_id", intr_id, 5'd4);
      chk("lvl_e", e_intr, 1'b1);
      chk("lvl_t", t_intr, 1'b0);
      rd(OFF_CLAIM, v); chk("lvl_claim", v, 32'd4);
      src_i[3] = 1'b0;
      settle(SS + 2);
      ack();
      rd(OFF_PENDING, v); chk("lvl_pend_clr", v, 32'h0);
      chk("svc_noreq", intr_req, 1'b0);
      done();
      @(negedge clk); src_i[3] = 1'b1;
      wait_req("lvl_repend", SS + 3);
      chk("lvl_repend_id", intr_id, 5'd4);
      src_i[3] = 1'b0;
      settle(SS + 2); ack(); done();
      wr(OFF_ENABLE, 32'h0);

      // Edge source 0: one pulse, one request
      wr(OFF_MODE, 32'h01);
      wr(OFF_ENABLE, 32'h01);
      @(negedge clk); src_i[0] = 1'b1;
      @(negedge clk); src_i[0] = 1'b0;
      wait_req("edge_req", SS + 3);
      chk("edge_id", intr_id, 5'd1);
      ack(); done();
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (intr_req) seen = 1'b1;
      end
      chk("edge_once", seen, 1'b0);
      wr(OFF_MODE, 32'h0);
      wr(OFF_ENABLE, 32'h0);

      // Priority 2 vs 5, and disable during REQ keeps the latched id
      wr(OFF_ENABLE, 32'h24);
      @(negedge clk); src_i[2] = 1'b1; src_i[5] = 1'b1;
      wait_req("pri_req", SS + 3);
      chk("pri_id3", intr_id, 5'd3);
      wr(OFF_ENABLE, 32'h20);
      chk("dis_hold_req", intr_req, 1'b1);
      chk("dis_hold_id", intr_id, 5'd3);
      src_i[2] = 1'b0; src_i[5] = 1'b0;
      settle(SS + 2); ack(); done();
      wait_req("pri_req6", 4);
      chk("pri_id6", intr_id, 5'd6);
      ack(); done();
      rd(OFF_PENDING, v); chk("pri_pend_clr", v, 32'h0);
      wr(OFF_ENABLE, 32'h0);

      // W1C and unmapped offset
      @(negedge clk); src_i[7] = 1'b1;
      settle(SS + 2);
      rd(OFF_PENDING, v); chk("w1c_set", v, 32'h80);
      chk("dis_noreq", intr_req, 1'b0);
      src_i[7] = 1'b0;
      settle(SS + 2);
      wr(OFF_PENDING, 32'h80);
      rd(OFF_PENDING, v); chk("w1c_clr", v, 32'h0);
      wr(5'h02, 32'hFFFF_FFFF);
      rd(5'h02, v); chk("unmapped", v, 32'h0);

`ifdef INTR_CTRL_TIMER_EN
      // Timer beats an enabled pending source 1
      wr(OFF_ENABLE, 32'h40);
      @(negedge clk); src_i[6] = 1'b1;
      wait_req("tmr_pre_req", SS + 3);
      src_i[6] = 1'b0;
      settle(SS + 2); ack();
      src_i[1] = 1'b1;
      wr(OFF_ENABLE, 32'h42);
      wr(OFF_MCMP_HI, 32'h0);
      wr(OFF_MCMP_LO, 32'd20);
      wr(OFF_MTIME_HI, 32'h0);
      wr(OFF_MTIME_LO, 32'h0);
      settle(30);
      done();
      wait_req("tmr_req", 3);
      chk("tmr_id", intr_id, 5'd0);
      chk("tmr_t", t_intr, 1'b1);
      chk("tmr_e", e_intr, 1'b0);
      ack();
      wr(OFF_MCMP_HI, 32'hFFFF_FFFF);
      done();
      wait_req("tmr_src1_req", 3);
      chk("tmr_src1_id", intr_id, 5'd2);
      src_i[1] = 1'b0;
      settle(SS + 2); ack(); done();
      wr(OFF_ENABLE, 32'h0);
`else
      wr(OFF_MTIME_LO, 32'h5);
      rd(OFF_MTIME_LO, v); chk("notmr_mtime", v, 32'h0);
      chk("notmr_t", t_intr, 1'b0);
`endif

      // Reset while in SERVICE
      wr(OFF_ENABLE, 32'h10);
      @(negedge clk); src_i[4] = 1'b1;
      wait_req("rst_svc_req", SS + 3);
      ack();
      chk("rst_svc_id_pre", intr_id, 5'd5);
      @(negedge clk); #2 rst = 1'b0;
      #1;
      chk("arst_req", intr_req, 1'b0);
      chk("arst_id", intr_id, 5'd0);
      chk("arst_e", e_intr, 1'b0);
      chk("arst_t", t_intr, 1'b0);
      rd(OFF_ENABLE, v); chk("arst_en", v, 32'h0);
`ifdef INTR_CTRL_TIMER_EN
      rd(OFF_MCMP_LO, v); chk("arst_mcmp_lo", v, 32'hFFFF_FFFF);
      rd(OFF_MCMP_HI, v); chk("arst_mcmp_hi", v, 32'hFFFF_FFFF);
`endif
      src_i[4] = 1'b0;
      @(negedge clk); rst = 1'b1;
      settle(SS + 3);
      chk("post_rst_noreq", intr_req, 1'b0);

`ifdef INTR_CTRL_TIMER_EN
      // MTIME wrap
      wr(OFF_MTIME_HI, 32'hFFFF_FFFF);
      @(negedge clk);
      reg_addr = OFF_MTIME_LO; reg_wdata = 32'hFFFF_FFFF; reg_wr = 1'b1;
      @(negedge clk);
      reg_wr = 1'b0;
      #1 chk("wrap_max", reg_rdata, 32'hFFFF_FFFF);
      @(negedge clk);
      #1 chk("wrap_lo0", reg_rdata, 32'h0);
      @(negedge clk);
      reg_addr = OFF_MTIME_HI;
      #1 chk("wrap_hi0", reg_rdata, 32'h0);
      wr(OFF_MCMP_LO, 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 8, number of external interrupt sources (legal range 1..31).
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser depth per source (legal range 2..3).
REQ-003 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 Port rst, input, 1, asynchronous active-low reset.
REQ-005 Port src_i, input, NUM_SRC, asynchronous external interrupt lines.
REQ-006 Port reg_addr, input, 5, byte offset of the register access.
REQ-007 Port reg_wr, input, 1, write strobe.
REQ-008 Port reg_wdata, input, 32, write data.
REQ-009 Port reg_rdata, output, 32, combinational read data for reg_addr.
REQ-010 Port intr_req, output, 1, interrupt request to the core.
REQ-011 Port intr_id, output, 5, id of the requested interrupt (0 = timer, k+1 = source k).
REQ-012 Port intr_ack, input, 1, core takes the trap this cycle.
REQ-013 Port intr_done, input, 1, core retires mret.
REQ-014 Port e_intr / t_intr, output, 1 each, external or timer class of the active request, to the CSR file.

Function
REQ-015 Each source passes through SYNC_STAGES flops, then level or rising-edge detection per MODE bit (1 = edge).
REQ-016 PENDING[k] sets on a detected event and clears on claim (ack of id k+1) or on W1C write; a set and a clear in the same cycle leave it set.
REQ-017 Register map: 0x00 PENDING (R, W1C), 0x04 ENABLE (RW), 0x08 MODE (RW), 0x0C CLAIM (R, current intr_id), 0x10/0x14 MTIME lo/hi (RW), 0x18/0x1C MTIMECMP lo/hi (RW); unmapped offsets read 0, ignore writes.
REQ-018 Winner = timer if timer pending, else lowest-index k with PENDING[k] & ENABLE[k].
REQ-019 FSM IDLE: a winner exists -> REQ next cycle, winner latched into intr_id.
REQ-020 FSM REQ: intr_req=1, intr_id held stable; intr_ack -> SERVICE, claim performed the same edge.
REQ-021 FSM SERVICE: intr_req=0, no new request; intr_done -> IDLE; no nesting.
REQ-022 intr_ack outside REQ and intr_done outside SERVICE are ignored.
REQ-023 e_intr = intr_req & (intr_id != 0); t_intr = intr_req & (intr_id == 0).
REQ-024 A pending bit disabled while in REQ does not withdraw the request; the latched id is delivered.

Reset
REQ-025 rst low asynchronously: FSM IDLE, PENDING/ENABLE/MODE/sync flops/MTIME = 0, MTIMECMP = all-ones, all outputs 0.
REQ-026 Reset during REQ or SERVICE drops intr_req immediately; no claim is recorded.

Configuration
REQ-027 Macro INTR_CTRL_TIMER_EN: when defined, 64-bit MTIME increments by 1 every cycle, wraps at 2^64-1 -> 0, and timer is pending while MTIME >= MTIMECMP (unsigned); a register write to MTIME takes priority over the increment.
REQ-028 Without INTR_CTRL_TIMER_EN: no timer flops, offsets 0x10-0x1C read 0, id 0 is never raised, t_intr is tied 0.

Structure
REQ-029 Package intr_pkg holds register offset constants, the FSM state enum (IDLE, REQ, SERVICE), ID_W = 5, and TIMER_ID = 0.
REQ-030 Sub-module intr_sync (synchroniser + edge detect, one instance per source via generate).

Verification
REQ-031 Level src_i[3]=1, ENABLE=0x08 -> intr_req within SYNC_STAGES+2 cycles, intr_id=4, e_intr=1; ack -> PENDING[3]=0, then re-pends while the line stays high.
REQ-032 Edge MODE[0]=1, 1-cycle pulse on src_i[0] -> exactly one request, id 1; intr_req stays 0 after intr_done.
REQ-033 Sources 2 and 5 pending together -> id 3 served first; after done, id 6 served.
REQ-034 TIMER_EN, MTIMECMP=20, MTIME=0 with src 1 also pending -> timer id 0 wins at MTIME=20, t_intr=1.
REQ-035 rst low while in SERVICE -> all outputs 0 asynchronously, MTIMECMP reads 0xFFFFFFFF for both halves.
REQ-036 MTIME=0xFFFF_FFFF_FFFF_FFFF -> next cycle reads 0.
